sid_voice_arbiter: RTL and testbench

- Shares one SID voice parameter bus (frequency/attack/sustain/waveform) between three requesters: drums, bass and fx.
- Uses fixed priority with a minimum gate time and a forced gate-off release gap before any ownership change, so that handover does not click.
- Sits between the sequencer/trigger sources and the voice input.

---
 rtl/sid_voice_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sid_voice_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_arbiter.sv
// -----------------------------------------------------------------------------
// sid_voice_arbiter
//
// Shares one SID voice parameter bus between three requesters (drums, bass,
// fx). Priority is fixed: drums (index 0) are highest and fx (index 2) lowest.
// Each grant holds the gate high for at least MIN_GATE cycles. Before ownership
// can change, the gate is forced low for exactly REL_GAP cycles, so that the
// envelope releases cleanly and the handover does not click.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active low
//   req[2:0]     request per requester, bit 0 = highest priority
//   req_freq     requester i frequency at [16i+15:16i]
//   req_attack   requester i attack/decay at [8i+7:8i]
//   req_sustain  requester i sustain/release at [8i+7:8i]
//   req_wave     requester i waveform byte at [8i+7:8i] (bit 0 ignored)
//   frequency    voice frequency (latched on grant)
//   attack       voice attack/decay (latched on grant)
//   sustain      voice sustain/release (latched on grant)
//   waveform     voice waveform, bit 0 = gate
//   grant        one-hot current owner, non-zero in GATE only
//   busy         high in GATE or RELEASE
//   preempt      one-cycle pulse when a higher-priority request forces release
// -----------------------------------------------------------------------------
module sid_voice_arbiter #(
    parameter int CNT_W    = 16,
    parameter int MIN_GATE = 1024,
    parameter int REL_GAP  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [47:0] req_freq,
    input  logic [23:0] req_attack,
    input  logic [23:0] req_sustain,
    input  logic [23:0] req_wave,
    output logic [15:0] frequency,
    output logic [7:0]  attack,
    output logic [7:0]  sustain,
    output logic [7:0]  waveform,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        preempt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_GATE_C = CNT_W'(MIN_GATE);
    localparam logic [CNT_W-1:0] REL_GAP_C  = CNT_W'(REL_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] gate_cnt;
    logic [CNT_W-1:0] rel_cnt;

    // Lowest set request bit, isolated as a one-hot vector.
    logic [2:0] winner;
    assign winner = req & (~req + 3'd1);

    // Parameters of the arbitration winner.
    logic [15:0] sel_freq;
    logic [7:0]  sel_attack;
    logic [7:0]  sel_sustain;
    logic [7:0]  sel_wave;

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_freq    = req_freq[15:0];
        sel_attack  = req_attack[7:0];
        sel_sustain = req_sustain[7:0];
        sel_wave    = req_wave[7:0];
        case (winner)
            3'b010: begin
                sel_freq    = req_freq[31:16];
                sel_attack  = req_attack[15:8];
                sel_sustain = req_sustain[15:8];
                sel_wave    = req_wave[15:8];
            end
            3'b100: begin
                sel_freq    = req_freq[47:32];
                sel_attack  = req_attack[23:16];
                sel_sustain = req_sustain[23:16];
                sel_wave    = req_wave[23:16];
            end
            default: ;
        endcase
    end

    // In GATE the grant register names the owner, so it doubles as the
    // owner mask. grant - 1 is the mask of every higher-priority index.
    logic owner_drop;
    logic higher_req;
    logic gate_done;
    logic arb_point;

    assign owner_drop = (req & grant) == 3'b000;
    assign higher_req = (req & (grant - 3'd1)) != 3'b000;
    assign gate_done  = gate_cnt >= MIN_GATE_C;
    assign arb_point  = (state == IDLE) ||
                        ((state == RELEASE) && (rel_cnt == REL_GAP_C));

    // NOTE: all state and registered outputs use non-blocking assignments so
    // that every register samples pre-edge values, whatever the update order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gate_cnt  <= '0;
            rel_cnt   <= '0;
            frequency <= '0;
            attack    <= '0;
            sustain   <= '0;
            waveform  <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;

            if (arb_point && (req != 3'b000)) begin
                // New grant (also a retrigger of the previous owner): latch
                // the winner's parameters and raise the gate.
                state     <= GATE;
                grant     <= winner;
                busy      <= 1'b1;
                gate_cnt  <= CNT_ONE;
                rel_cnt   <= '0;
                frequency <= sel_freq;
                attack    <= sel_attack;
                sustain   <= sel_sustain;
                waveform  <= sel_wave | 8'h01;
            end else begin
                case (state)
                    IDLE: ;

                    GATE: begin
                        if (gate_done && (owner_drop || higher_req)) begin
                            // Parameters stay put so the release tail keeps
                            // the old pitch; only the gate bit drops.
                            state    <= RELEASE;
                            grant    <= 3'b000;
                            waveform <= waveform & 8'hFE;
                            rel_cnt  <= CNT_ONE;
                            preempt  <= higher_req;
                        end else if (gate_cnt != '1) begin
                            gate_cnt <= gate_cnt + CNT_ONE;
                        end
                    end

                    RELEASE: begin
                        if (rel_cnt == REL_GAP_C) begin
                            // Gap finished with no request pending.
                            state   <= IDLE;
                            busy    <= 1'b0;
                            rel_cnt <= '0;
                        end else begin
                            rel_cnt <= rel_cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        grant    <= 3'b000;
                        busy     <= 1'b0;
                        waveform <= waveform & 8'hFE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sid_voice_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sid_voice_arbiter
//
// Directed scenarios followed by random traffic. A behavioural model written
// from the arbitration rules (phase, owner index, age in cycles) predicts every
// output each cycle; a few scenario checks use hand-derived constants.
// -----------------------------------------------------------------------------
module tb_sid_voice_arbiter;

    localparam int MIN_GATE = 4;
    localparam int REL_GAP  = 2;
    localparam int CNT_MAX  = 65535;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [47:0] req_freq;
    logic [23:0] req_attack;
    logic [23:0] req_sustain;
    logic [23:0] req_wave;
    logic [15:0] frequency;
    logic [7:0]  attack;
    logic [7:0]  sustain;
    logic [7:0]  waveform;
    logic [2:0]  grant;
    logic        busy;
    logic        preempt;

    int checks = 0;
    int errors = 0;

    sid_voice_arbiter #(
        .CNT_W   (16),
        .MIN_GATE(MIN_GATE),
        .REL_GAP (REL_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_freq   (req_freq),
        .req_attack (req_attack),
        .req_sustain(req_sustain),
        .req_wave   (req_wave),
        .frequency  (frequency),
        .attack     (attack),
        .sustain    (sustain),
        .waveform   (waveform),
        .grant      (grant),
        .busy       (busy),
        .preempt    (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = idle, 1 = gate high, 2 = forced-low gap
    int          m_phase = 0;
    int          m_owner = 0;
    int          m_age   = 0;
    logic [15:0] m_freq  = '0;
    logic [7:0]  m_att   = '0;
    logic [7:0]  m_sus   = '0;
    logic [7:0]  m_wav   = '0;
    logic        m_pre   = 1'b0;

    function automatic int lowest_req(input logic [2:0] r);
        for (int i = 0; i < 3; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT will see.
    task automatic model_step();
        int  w;
        bit  higher;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_age = 0;
            m_freq = '0; m_att = '0; m_sus = '0; m_wav = '0; m_pre = 1'b0;
            return;
        end
        m_pre = 1'b0;
        if (m_phase == 1) begin
            higher = 1'b0;
            for (int j = 0; j < m_owner; j++) begin
                if (req[j]) higher = 1'b1;
            end
            if (m_age >= MIN_GATE && (!req[m_owner] || higher)) begin
                m_phase = 2;
                m_age   = 1;
                m_pre   = higher;
            end else if (m_age < CNT_MAX) begin
                m_age++;
            end
        end else if (m_phase == 0 || m_age == REL_GAP) begin
            w = lowest_req(req);
            if (w >= 0) begin
                m_phase = 1;
                m_owner = w;
                m_age   = 1;
                m_freq  = req_freq[16*w +: 16];
                m_att   = req_attack[8*w +: 8];
                m_sus   = req_sustain[8*w +: 8];
                m_wav   = req_wave[8*w +: 8];
            end else begin
                m_phase = 0;
                m_age   = 0;
            end
        end else begin
            m_age++;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic compare_model();
        logic [7:0] exp_wave;
        logic [2:0] exp_grant;
        exp_wave  = {m_wav[7:1], (m_phase == 1) ? 1'b1 : 1'b0};
        exp_grant = (m_phase == 1) ? 3'(1 << m_owner) : 3'b000;
        check("wave",    waveform,  exp_wave);
        check("grant",   grant,     exp_grant);
        check("busy",    busy,      (m_phase != 0) ? 1'b1 : 1'b0);
        check("preempt", preempt,   m_pre);
        check("freq",    frequency, m_freq);
        check("attack",  attack,    m_att);
        check("sustain", sustain,   m_sus);
    endtask

    // One clock: model sees the same inputs as the DUT's coming edge, then
    // outputs are sampled on the falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_params();
        req_freq    = {16'($urandom), 32'($urandom)};
        req_attack  = 24'($urandom);
        req_sustain = 24'($urandom);
        req_wave    = 24'($urandom);
    endtask

    // Watchdog: the stimulus is bounded, this only guards against a stuck sim.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  trace;
        logic [14:0] gtrace;
        logic [8:0]  gtrace3;
        int          cnt_a;
        int          cnt_b;

        rst_n = 1'b0;
        req   = 3'b111;
        rand_params();
        @(negedge clk);

        // 1. reset with all requests high, then release
        ticks(2);
        check("rst_wave",  waveform, 8'h00);
        check("rst_grant", grant,    3'b000);
        check("rst_busy",  busy,     1'b0);
        rst_n = 1'b1;
        tick();
        check("rst_first_grant", grant, 3'b001);
        check("rst_first_freq",  frequency, req_freq[15:0]);
        req = 3'b000;
        ticks(10);

        // 2. single-cycle pulse on bass: gate 4 high, 2 low, then idle
        rand_params();
        req_freq[31:16] = 16'd22;
        req = 3'b010;
        tick();
        trace[7] = waveform[0];
        req = 3'b000;
        req_freq[31:16] = 16'd999;
        for (int k = 6; k >= 0; k--) begin
            tick();
            trace[k] = waveform[0];
        end
        check("short_trace", trace, 8'b1111_0000);
        check("short_freq",  frequency, 16'd22);
        check("short_idle",  busy, 1'b0);

        // 3. drums preempt fx at gate_cnt = 2
        rand_params();
        req_freq[47:32] = 16'd4096;
        req = 3'b100;
        ticks(2);
        req = 3'b101;
        req_freq[15:0] = 16'h1234;
        cnt_a = 0;
        for (int k = 4; k >= 0; k--) begin
            tick();
            gtrace[3*k +: 3] = grant;
            if (preempt) cnt_a++;
        end
        check("preempt_grants", gtrace, {3'b100, 3'b100, 3'b000, 3'b000, 3'b001});
        check("preempt_pulses", cnt_a, 1);
        check("preempt_freq",   frequency, 16'h1234);
        req = 3'b000;
        ticks(10);

        // 4. fx never preempts drums
        rand_params();
        req = 3'b101;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant == 3'b001) cnt_a++;
            if (preempt) cnt_b++;
        end
        check("nopre_grant_cycles", cnt_a, 20);
        check("nopre_pulses",       cnt_b, 0);
        req = 3'b100;
        for (int k = 2; k >= 0; k--) begin
            tick();
            gtrace3[3*k +: 3] = grant;
        end
        check("nopre_handover", gtrace3, {3'b000, 3'b000, 3'b100});
        req = 3'b000;
        ticks(10);

        // 5a. bass held for 12 cycles: gate never drops
        rand_params();
        req = 3'b010;
        cnt_a = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (grant == 3'b010 && waveform[0]) cnt_a++;
        end
        check("hold_gate_cycles", cnt_a, 12);
        req = 3'b000;
        ticks(6);

        // 5b. retrigger during the gap re-latches parameters
        req = 3'b010;
        ticks(5);
        req = 3'b000;
        tick();
        check("retrig_rel1_gate", waveform[0], 1'b0);
        req = 3'b010;
        req_freq[31:16] = 16'hBEEF;
        tick();
        check("retrig_rel2_gate", waveform[0], 1'b0);
        tick();
        check("retrig_grant", grant, 3'b010);
        check("retrig_freq",  frequency, 16'hBEEF);

        // 6. reset in the first gap cycle
        ticks(4);
        req = 3'b000;
        tick();
        check("midrel_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrel_rst_wave", waveform, 8'h00);
        check("midrel_rst_busy", busy, 1'b0);
        check("midrel_rst_freq", frequency, 16'h0000);
        rst_n = 1'b1;
        req = 3'b100;
        tick();
        check("midrel_rearb", grant, 3'b100);
        req = 3'b000;
        ticks(8);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) rand_params();
            rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
